// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: collects received bytes into NUM_MAT row-major matrices,
// then offers a registered random-read port and a tick-paced display sweep.
//
// state   | meaning
// --------+--------------------------------------------------------------
// LOAD    | accepting bytes into mem[wr_ptr] until DEPTH elements are held
// READY   | frame complete; waiting for tick & disp_en to start a sweep
// DISPLAY | sweep in progress; each enabled tick presents the next element
module uart_matrix_loader #(
  parameter  int ROWS    = 2,
  parameter  int COLS    = 2,
  parameter  int NUM_MAT = 2,
  parameter  int DATA_W  = 8,
  localparam int DEPTH   = NUM_MAT * ROWS * COLS,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_err,
  input  logic              reload,
  input  logic              disp_en,
  input  logic              tick,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              loaded,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic [AW-1:0]     disp_idx,
  output logic              frame_err,
  output logic              overrun
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    READY   = 2'd1,
    DISPLAY = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     disp_nxt;
  logic [DATA_W-1:0] wr_val;
  logic              wr_evt, drop_evt, ovr_evt, start_evt, step_evt;
  logic [DATA_W-1:0] mem [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state and event decode; reload overrides everything, including a same-cycle byte
  always_comb begin
    state_nxt = state;
    wr_evt    = 1'b0;
    drop_evt  = 1'b0;
    ovr_evt   = 1'b0;
    start_evt = 1'b0;
    step_evt  = 1'b0;
    disp_nxt  = disp_idx + AW'(1);
    wr_val    = DATA_W'(rx_byte);
    if (reload) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (rx_valid) begin
            if (rx_err) begin
              drop_evt = 1'b1;
            end else begin
              wr_evt = 1'b1;
              if (wr_ptr == LAST) state_nxt = READY;
            end
          end
        end
        READY: begin
          ovr_evt = rx_valid;
          if (tick && disp_en) begin
            start_evt = 1'b1;
            // a single-element frame is fully presented by the starting tick
            if (LAST != '0) state_nxt = DISPLAY;
          end
        end
        DISPLAY: begin
          ovr_evt = rx_valid;
          if (tick && disp_en) begin
            step_evt = 1'b1;
            if (disp_nxt == LAST) state_nxt = READY;
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Element storage; deliberately not reset so reload keeps old contents
  always_ff @(posedge clk) begin
    if (wr_evt) mem[wr_ptr] <= wr_val;
  end

  // Registered random read; out-of-range addresses read as zero, same-cycle write returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rd_data <= '0;
    else if ({1'b0, rd_addr} < DEPTH_W) rd_data <= mem[rd_addr];
    else                              rd_data <= '0;
  end

  // Load pointer, display sweep outputs and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      disp_idx    <= '0;
      loaded      <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (reload) begin
        wr_ptr    <= '0;
        disp_idx  <= '0;
        loaded    <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (wr_evt) begin
          if (wr_ptr == LAST) begin
            wr_ptr <= '0;
            loaded <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        if (drop_evt) frame_err <= 1'b1;
        if (ovr_evt)  overrun   <= 1'b1;
        if (start_evt) begin
          disp_idx    <= '0;
          value       <= mem[0];
          value_valid <= 1'b1;
        end
        if (step_evt) begin
          disp_idx    <= disp_nxt;
          value       <= mem[disp_nxt];
          value_valid <= 1'b1;
        end
      end
    end
  end

endmodule
